// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives a synchronous-read instruction port
// and presents {pc, inst} to decode. Optional perf counters: define IFETCH_PERF_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [MEM_WIDTH-1:0] imem_addr,
    output logic                 imem_req,
    input  logic [31:0]          imem_data,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_inst
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_killed
`endif
);

    logic [31:0] fpc_q, fpc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_v_q, inflight_v_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];

    logic [31:0] target_pc;
    logic [2:0]  occ;
    logic        deq, fifo_pop, bypass, enq, issue, tail;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign tail      = head_q ^ count_q[0];

    always_comb begin
        out_valid = !rst && ((count_q != 2'd0) || inflight_v_q);
        if (count_q != 2'd0) begin
            out_pc   = fifo_pc_q[head_q];
            out_inst = fifo_inst_q[head_q];
        end else begin
            out_pc   = inflight_pc_q;
            out_inst = imem_data;
        end
        deq      = out_valid && out_ready;
        fifo_pop = deq && (count_q != 2'd0);
        bypass   = deq && (count_q == 2'd0);
        enq      = inflight_v_q && !redirect_valid && !bypass;
        // occupancy left once this cycle's response and dequeue have settled
        occ      = 3'(count_q) + 3'(inflight_v_q) - 3'(deq);
        issue    = redirect_valid || (occ < 3'd2);
        imem_req = !rst && issue;
        imem_addr = redirect_valid ? target_pc[MEM_WIDTH+1:2] : fpc_q[MEM_WIDTH+1:2];
    end

    always_comb begin
        fpc_d         = fpc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_v_d  = inflight_v_q;
        count_d       = count_q;
        head_d        = head_q;
        if (redirect_valid) begin
            count_d       = 2'd0;
            head_d        = 1'b0;
            inflight_v_d  = 1'b1;
            inflight_pc_d = target_pc;
            fpc_d         = target_pc + 32'd4;
        end else begin
            count_d = count_q + {1'b0, enq} - {1'b0, fifo_pop};
            head_d  = head_q ^ fifo_pop;
            if (issue) begin
                inflight_pc_d = fpc_q;
                fpc_d         = fpc_q + 32'd4;
                inflight_v_d  = 1'b1;
            end else begin
                inflight_v_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_v_q  <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_v_q  <= inflight_v_d;
            count_q       <= count_d;
            head_q        <= head_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q alone.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk) begin
            if (enq && (tail == 1'(gi))) begin
                fifo_pc_q[gi]   <= inflight_pc_q;
                fifo_inst_q[gi] <= imem_data;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_killed_q;
    logic [32:0] killed_sum;

    assign killed_sum   = {1'b0, perf_killed_q} + 33'(count_q) + 33'(inflight_v_q);
    assign perf_fetched = perf_fetched_q;
    assign perf_killed  = perf_killed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'd0;
            perf_killed_q  <= 32'd0;
        end else begin
            if (imem_req && (perf_fetched_q != 32'hFFFF_FFFF))
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect_valid)
                perf_killed_q <= killed_sum[32] ? 32'hFFFF_FFFF : killed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: scoreboard of expected PCs plus directed checks.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_WIDTH = 16;

    logic                 clk;
    logic                 rst;
    logic [MEM_WIDTH-1:0] imem_addr;
    logic                 imem_req;
    logic [31:0]          imem_data;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [31:0]          out_inst;
`ifdef IFETCH_PERF_EN
    logic [31:0]          perf_fetched;
    logic [31:0]          perf_killed;
    logic [31:0]          killed_before;
`endif

    ifetch_unit #(.RESET_PC(RESET_PC), .MEM_WIDTH(MEM_WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_killed    (perf_killed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word i holds 32'h1000_0000 + i, one-cycle read latency.
    always @(posedge clk) imem_data <= 32'h1000_0000 + 32'(imem_addr);

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic [31:0] exp_q [$];
    logic [31:0] next_exp;
    logic        hold_q;
    logic [31:0] hold_pc, hold_inst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h1000_0000 + {16'h0, pc[17:2]};
    endfunction

    // Sample at the falling edge: hold stability, then scoreboard on each handshake.
    task automatic mid();
        logic [31:0] ep;
        @(negedge clk);
        if (hold_q && !rst) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_pc", out_pc, hold_pc);
            check("hold_inst", out_inst, hold_inst);
        end
        if (out_valid && out_ready && !redirect_valid && !rst) begin
            while (exp_q.size() < 4) begin
                exp_q.push_back(next_exp);
                next_exp = next_exp + 32'd4;
            end
            ep = exp_q.pop_front();
            check("sb_pc", out_pc, ep);
            check("sb_inst", out_inst, inst_of(ep));
            n_txn++;
            $display("txn %0d pc=%h inst=%h", n_txn, out_pc, out_inst);
        end
        hold_q    = out_valid && !out_ready && !redirect_valid && !rst;
        hold_pc   = out_pc;
        hold_inst = out_inst;
        if (rst) begin
            exp_q.delete();
            next_exp = RESET_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            next_exp = redirect_pc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            mid();
            adv();
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        hold_q         = 1'b0;
        next_exp       = RESET_PC;
        adv();
        mid();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        adv();
        rst = 1'b0;

        // cycle 0: first fetch issued, nothing presented yet
        mid();
        check("c0_valid", {31'b0, out_valid}, 32'd0);
        check("c0_req", {31'b0, imem_req}, 32'd1);
        check("c0_addr", 32'(imem_addr), 32'h0);
        adv();
        // cycle 1: reset PC presented via bypass
        mid();
        check("c1_valid", {31'b0, out_valid}, 32'd1);
        check("c1_pc", out_pc, RESET_PC);
        adv();
        run(2);

        // backpressure from cycle 4 for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("bp_pc", out_pc, 32'h0000_000C);
            check("bp_inst", out_inst, 32'h1000_0003);
            if (i >= 2) check("bp_req", {31'b0, imem_req}, 32'd0);
            adv();
        end
        out_ready = 1'b1;
        run(4);

        // redirect while streaming
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        mid();
        check("rd_req", {31'b0, imem_req}, 32'd1);
        check("rd_addr", 32'(imem_addr), 32'h10);
        adv();
        redirect_valid = 1'b0;
        mid();
        check("rd_valid", {31'b0, out_valid}, 32'd1);
        check("rd_pc", out_pc, 32'h0000_0040);
        check("rd_inst", out_inst, 32'h1000_0010);
        adv();
        run(4);

        // redirect with the FIFO full
        out_ready = 1'b0;
        run(4);
`ifdef IFETCH_PERF_EN
        killed_before = perf_killed;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        mid();
        check("full_req", {31'b0, imem_req}, 32'd1);
        check("full_addr", 32'(imem_addr), 32'h20);
        adv();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        mid();
        check("full_pc", out_pc, 32'h0000_0080);
`ifdef IFETCH_PERF_EN
        check("full_killed", perf_killed - killed_before, 32'd2);
`endif
        adv();
        run(3);

        // misaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        mid();
        check("mis_addr", 32'(imem_addr), 32'h10);
        adv();
        redirect_valid = 1'b0;
        mid();
        check("mis_pc", out_pc, 32'h0000_0040);
        adv();
        run(3);

        // back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        mid();
        adv();
        redirect_pc    = 32'h0000_0200;
        mid();
        adv();
        redirect_valid = 1'b0;
        mid();
        check("b2b_pc", out_pc, 32'h0000_0200);
        adv();
        run(3);

        // reset during backpressure
        out_ready = 1'b0;
        run(3);
        rst = 1'b1;
        mid();
        check("rst2_valid", {31'b0, out_valid}, 32'd0);
        check("rst2_req", {31'b0, imem_req}, 32'd0);
        adv();
        rst       = 1'b0;
        out_ready = 1'b1;
        mid();
        check("rst2_c0_valid", {31'b0, out_valid}, 32'd0);
        adv();
        mid();
        check("rst2_c1_pc", out_pc, RESET_PC);
        adv();
        run(3);

        // wrap past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        mid();
        adv();
        redirect_valid = 1'b0;
        mid();
        check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        check("wrap_inst0", out_inst, 32'h1000_FFFF);
        adv();
        mid();
        check("wrap_pc1", out_pc, 32'h0000_0000);
        check("wrap_inst1", out_inst, 32'h1000_0000);
        adv();
        run(3);

        // random backpressure with occasional redirects
        for (int i = 0; i < 120; i++) begin
            out_ready      = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            mid();
            adv();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        run(6);

        check("progress", {31'b0, (n_txn > 60)}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Owns the fetch PC and drives the word address into the instruction port of the synchronous-read `memory`. Read data returns one cycle after the address is sampled.
- Presents {pc, instruction} pairs to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from downstream, discarding all wrong-path instructions it holds or has in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first byte address fetched after reset.
- MEM_WIDTH, 16, word-address width of the instruction memory port.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  MEM_WIDTH  word address, equal to issue_pc[MEM_WIDTH+1:2].
- imem_req  out  1  high when this cycle's address is a real fetch. The memory ignores it; it is used for bookkeeping and perf.
- imem_data  in  32  read data for the address sampled on the previous edge.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_pc  out  32  byte PC of the presented instruction.
- out_inst  out  32  the presented instruction word.

Behaviour:
- State:
  - fpc: next sequential fetch PC.
  - inflight_v / inflight_pc: the fetch issued last cycle, whose data is on imem_data this cycle.
  - A 2-entry FIFO of {pc, inst}, with count in 0..2.
- Reset (rst=1 at an edge):
  - fpc<=RESET_PC, inflight_v<=0, count<=0.
  - Any operation in progress is abandoned, with no residue.
  - While rst=1: out_valid=0, imem_req=0.
- Cycle numbering: cycle 0 is the first cycle with rst=0.
- Presentation:
  - out_valid = (count>0) | inflight_v.
  - If count>0, the head is the FIFO head.
  - Otherwise the head is bypassed from {inflight_pc, imem_data}. This gives zero-latency presentation of fresh data.
- deq = out_valid & out_ready.
- Enqueue: the inflight response is written to the FIFO when inflight_v=1, no redirect is active, and it was not consumed through the bypass this cycle.
- Issue rule (no redirect):
  - imem_req = (count + inflight_v - deq) < 2.
  - When issuing: imem_addr=fpc[MEM_WIDTH+1:2], inflight_pc<=fpc, fpc<=fpc+4, inflight_v<=1.
  - When not issuing: imem_addr holds fpc and inflight_v<=0.
- Throughput: one instruction per cycle when out_ready stays high.
  - First valid: cycle 1, out_pc=RESET_PC.
- Backpressure:
  - FIFO plus inflight never exceeds 2.
  - out_pc and out_inst are stable while out_valid=1 and out_ready=0.
  - No instruction is dropped or duplicated.
- Redirect (redirect_valid=1 at cycle N):
  - The FIFO is flushed (count<=0).
  - The response on imem_data at N is discarded.
  - The fetch is forced: imem_req=1 and imem_addr=redirect_pc[MEM_WIDTH+1:2], regardless of occupancy.
  - inflight_pc<={redirect_pc[31:2],2'b00}, inflight_v<=1, fpc<={redirect_pc[31:2],2'b00}+4.
  - out_valid at N is unmasked. A handshake in cycle N completes normally, and the consumer treats it as wrong-path.
  - Cycle N+1: out_valid=1 and out_pc = the aligned target.
  - Back-to-back redirects: the last one wins, and each one restarts the sequence above.
- Arithmetic:
  - fpc+4 wraps modulo 2^32.
  - imem_addr truncates the upper PC bits (memory aliasing is accepted).
- rst has priority over redirect_valid.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined, two extra output ports are added:
  - perf_fetched [31:0]: increments on every cycle with imem_req=1.
  - perf_killed [31:0]: increments by the number of entries discarded on redirect, i.e. count plus the response on imem_data that cycle.
  - Both counters are zeroed by rst and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Streaming: memory word i = 32'h1000_0000+i, RESET_PC=0, out_ready=1.
  - out_valid=1 from cycle 1.
  - out_pc = 0,4,8,… each cycle, with out_inst=32'h1000_0000+pc/4.
- Backpressure:
  - Drop out_ready at cycle 4 for 5 cycles: out_pc stays 0xC and out_inst stays constant; imem_req=0 once occupancy is 2.
  - Raise out_ready: the sequence resumes at 0xC,0x10,… with no gaps or duplicates.
- Redirect while streaming:
  - redirect_valid with redirect_pc=0x40 at cycle 6.
  - Cycle 7: out_pc=0x40, out_inst=0x1000_0010. Then 0x44,0x48,…, with no old-path PC appearing after cycle 6.
- Redirect with full FIFO: out_ready=0 (occupancy 2), then redirect to 0x80.
  - Next cycle: out_pc=0x80.
  - Under IFETCH_PERF_EN, perf_killed increases by 2.
- Misaligned target: redirect_pc=0x43 gives out_pc=0x40 and imem_addr=0x10 in the redirect cycle.
- Reset mid-stream:
  - Assert rst for 1 cycle during backpressure: out_valid=0 and imem_req=0 in that cycle.
  - Afterwards the sequence restarts at out_pc=RESET_PC in the cycle after the first fetch.
- Wrap: redirect to 0xFFFF_FFFC gives out_pc sequence 0xFFFF_FFFC, then 0x0000_0000.
